// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants and decode helper
package vga_timing_pkg;

   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

   localparam int CUENTA_W  = 10;

   function automatic logic en_rango(input logic [CUENTA_W-1:0] v, input int lo, input int hi);
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

endpackage

// File: rtl/contador_vertical_if.sv
// rtl/contador_vertical_if.sv - bundle of the vertical counter's count and decoded flags
interface contador_vertical_if;
   import vga_timing_pkg::*;

   logic [CUENTA_W-1:0] cuenta;
   logic                vsync;
   logic                video_on_v;
   logic                fin_cuadro;

   modport master (output cuenta, output vsync, output video_on_v, output fin_cuadro);
   modport slave  (input  cuenta, input  vsync, input  video_on_v, input  fin_cuadro);
endinterface

// File: rtl/contador_mod_n.sv
// rtl/contador_mod_n.sv - modulo-N up counter, synchronous active-low reset
module contador_mod_n #(
   parameter int WIDTH = 10,
   parameter int N     = 525
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   output logic [WIDTH-1:0] cuenta_o
);

   logic [WIDTH-1:0] cuenta_q;
   logic [WIDTH-1:0] cuenta_d;

   always_comb begin
      cuenta_d = cuenta_q + WIDTH'(1);
      if (cuenta_q == WIDTH'(N - 1)) begin
         cuenta_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         cuenta_q <= '0;
      end else begin
         cuenta_q <= cuenta_d;
      end
   end

   assign cuenta_o = cuenta_q;

endmodule

// File: rtl/contador_vertical.sv
// rtl/contador_vertical.sv - VGA vertical line counter with vsync/active/end-of-frame decode
module contador_vertical
   import vga_timing_pkg::*;
#(
   parameter int   V_DISPLAY    = vga_timing_pkg::V_DISPLAY,
   parameter int   V_FRONT      = vga_timing_pkg::V_FRONT,
   parameter int   V_SYNC       = vga_timing_pkg::V_SYNC,
   parameter int   V_BACK       = vga_timing_pkg::V_BACK,
   parameter logic VSYNC_ACTIVE = 1'b0
) (
   input  logic                Clk,
   input  logic                reset,
   output logic [CUENTA_W-1:0] cuenta,
   output logic                vsync,
   output logic                video_on_v,
   output logic                fin_cuadro
);

   localparam int V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int SYNC_FIRST = V_DISPLAY + V_FRONT;
   localparam int SYNC_LAST  = V_DISPLAY + V_FRONT + V_SYNC - 1;

   generate
      if (V_TOTAL > (1 << CUENTA_W)) begin : g_total_chk
         $error("contador_vertical: V_TOTAL does not fit the 10-bit count");
      end
   endgenerate

   contador_mod_n #(
      .WIDTH (CUENTA_W),
      .N     (V_TOTAL)
   ) u_contador (
      .clk_i    (Clk),
      .resetn_i (reset),
      .cuenta_o (cuenta)
   );

   // Flags are pure decodes of the registered count, so they line up with cuenta.
   assign video_on_v = (int'(cuenta) < V_DISPLAY);
   assign fin_cuadro = (int'(cuenta) == V_TOTAL - 1);
   assign vsync      = en_rango(cuenta, SYNC_FIRST, SYNC_LAST) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;

endmodule

// File: tb/tb_contador_vertical.sv
// tb/tb_contador_vertical.sv - scoreboard bench for contador_vertical, default and small parameter sets
module tb_contador_vertical;

   typedef struct {
      logic [9:0] c;
      logic       vs;
      logic       von;
      logic       fin;
      logic [9:0] c2;
      logic       vs2;
      logic       von2;
      logic       fin2;
   } exp_t;

   logic       Clk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] cuenta2;
   logic       vsync2, video_on_v2, fin_cuadro2;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   m  = 0;
   int   m2 = 0;
   exp_t sb_q[$];

   contador_vertical_if vif ();

   always #40 Clk = ~Clk;

   contador_vertical dut (
      .Clk        (Clk),
      .reset      (reset),
      .cuenta     (vif.cuenta),
      .vsync      (vif.vsync),
      .video_on_v (vif.video_on_v),
      .fin_cuadro (vif.fin_cuadro)
   );

   contador_vertical #(
      .V_DISPLAY    (4),
      .V_FRONT      (1),
      .V_SYNC       (1),
      .V_BACK       (1),
      .VSYNC_ACTIVE (1'b1)
   ) dut_small (
      .Clk        (Clk),
      .reset      (reset),
      .cuenta     (cuenta2),
      .vsync      (vsync2),
      .video_on_v (video_on_v2),
      .fin_cuadro (fin_cuadro2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance the reference model for one edge, push the expectation, then compare after the edge.
   task automatic tick();
      exp_t e;
      exp_t o;
      if (!reset) begin
         m  = 0;
         m2 = 0;
      end else begin
         m  = (m == 524) ? 0 : m + 1;
         m2 = (m2 == 6) ? 0 : m2 + 1;
      end
      e.c    = 10'(m);
      e.von  = (m < 480);
      e.vs   = !(m == 490 || m == 491);
      e.fin  = (m == 524);
      e.c2   = 10'(m2);
      e.von2 = (m2 < 4);
      e.vs2  = (m2 == 5);
      e.fin2 = (m2 == 6);
      sb_q.push_back(e);
      @(posedge Clk);
      #1;
      o = sb_q.pop_front();
      check("cuenta",      32'(vif.cuenta),     32'(o.c));
      check("vsync",       32'(vif.vsync),      32'(o.vs));
      check("video_on_v",  32'(vif.video_on_v), 32'(o.von));
      check("fin_cuadro",  32'(vif.fin_cuadro), 32'(o.fin));
      check("small_cuenta", 32'(cuenta2),       32'(o.c2));
      check("small_vsync",  32'(vsync2),        32'(o.vs2));
      check("small_von",    32'(video_on_v2),   32'(o.von2));
      check("small_fin",    32'(fin_cuadro2),   32'(o.fin2));
   endtask

   task automatic run_to(input int target);
      int n;
      n = 0;
      while (int'(vif.cuenta) != target && n < 1100) begin
         tick();
         n++;
      end
      check("run_to_reached", 32'(vif.cuenta), 32'(target));
   endtask

   int bnd_c  [6] = '{479, 480, 489, 490, 491, 492};
   bit bnd_von[6] = '{1, 0, 0, 0, 0, 0};
   bit bnd_vs [6] = '{1, 1, 1, 0, 0, 1};

   initial begin
      reset = 1'b0;
      #1;
      tick();
      tick();
      check("rst_cuenta", 32'(vif.cuenta),     32'd0);
      check("rst_von",    32'(vif.video_on_v), 32'd1);
      check("rst_vsync",  32'(vif.vsync),      32'd1);
      check("rst_fin",    32'(vif.fin_cuadro), 32'd0);

      reset = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("count10", 32'(vif.cuenta), 32'd10);

      for (int i = 0; i < 6; i++) begin
         run_to(bnd_c[i]);
         check($sformatf("bnd%0d_von", bnd_c[i]),   32'(vif.video_on_v), 32'(bnd_von[i]));
         check($sformatf("bnd%0d_vsync", bnd_c[i]), 32'(vif.vsync),      32'(bnd_vs[i]));
      end

      run_to(524);
      check("last_fin", 32'(vif.fin_cuadro), 32'd1);
      tick();
      check("wrap_cuenta", 32'(vif.cuenta),     32'd0);
      check("wrap_fin",    32'(vif.fin_cuadro), 32'd0);
      check("wrap_von",    32'(vif.video_on_v), 32'd1);

      for (int i = 0; i < 1050; i++) tick();
      check("two_frames", 32'(vif.cuenta), 32'd0);

      run_to(300);
      reset = 1'b0;
      tick();
      check("midrst_cuenta", 32'(vif.cuenta), 32'd0);
      reset = 1'b1;
      tick();
      check("resume1", 32'(vif.cuenta), 32'd1);
      tick();
      check("resume2", 32'(vif.cuenta), 32'd2);

      run_to(524);
      reset = 1'b0;
      tick();
      check("rst_at_524", 32'(vif.cuenta), 32'd0);
      reset = 1'b1;

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
